lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store sequencing controller between the execute stage and the single-ported data memory of the RISC-V core. Accepts one load or store per transaction. Checks alignment, then drives a word-aligned memory request with byte enables and waits for the acknowledge under a timeout. Returns the shifted and sign- or zero-extended load result (or store completion) as a one-cycle response pulse.

## Interface
Parameters:
- TIMEOUT, 255: max cycles `mem_req` is held without `mem_ack` before an error response; range 1..255.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_ctrl  in  3  load: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU; store: 000 SB, 001 SH, 010 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSBs significant
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  write strobe
- mem_addr  out  32  `{req_addr[31:2], 2'b00}`
- mem_be  out  4  byte-lane enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read word, valid with `mem_ack`
- mem_ack  in  1  memory completion
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal store ctrl, or timeout

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE: `req_ready`=1. On `req_valid`:
  - If the request is erroneous, latch the error and go to RESP.
  - Otherwise latch we/ctrl/addr/wdata, clear the timeout counter, and go to ACCESS.
- Misaligned requests:
  - Halfword (LH/LHU/SH) with addr[0]=1.
  - Word (LW/SW) with addr[1:0]≠0.
  - Load ctrl 101..111 is treated as LW, including the word alignment check.
- Store ctrl 011..111 is an illegal-ctrl error.
- ACCESS: `mem_req`=1 and outputs are stable from the latched request. The counter increments every cycle without ack.
  - `mem_ack` → capture the load result, go to RESP.
  - Counter reaching TIMEOUT without ack → error, go to RESP.
  - Ack in the same cycle the counter reaches TIMEOUT: the ack wins.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Load result, with s = addr[1:0]:
  - Shift: `mem_rdata >> (8*s)`.
  - LB: sign-extend bit 7. LH: sign-extend bit 15. LBU/LHU: zero-extend. LW: unchanged.
- Store lanes:
  - SB: wdata[7:0] replicated ×4, `mem_be` = 0001<<s.
  - SH: wdata[15:0] replicated ×2, `mem_be` = 0011<<s.
  - SW: `mem_be` = 1111.
- Loads drive `mem_be` = 1111 and `mem_we` = 0.
- `mem_ack` outside ACCESS is ignored.

## Timing
- Reset values: `req_ready`=1; `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `rsp_valid`, `rsp_data`, `rsp_err` all 0.
- Latency for an aligned access accepted at cycle 0 with ack in cycle 1:
  - `mem_req` high in cycle 1.
  - `rsp_valid` in cycle 2.
  - Next request accepted in cycle 3.
- Error detected in IDLE: `rsp_valid` + `rsp_err` in cycle 1, with no memory request issued.
- Timeout: `mem_req` is high for TIMEOUT cycles, then drops. The `rsp_err` pulse comes the following cycle.
- All memory-side outputs and rsp_* are registered.
- Reset asserted mid-ACCESS: immediate return to IDLE and `mem_req` drops asynchronously. The memory must tolerate an abandoned request.

## Structure
- Package `lsu_pkg` holds:
  - load/store ctrl encoding constants;
  - the FSM state enum;
  - the TIMEOUT counter width (8).
- Sub-module `load_extend` is combinational. Inputs: rdata, offset, ctrl. Output: the shifted and extended 32-bit result. It is instantiated once in lsu_ctrl.

## Test plan
- LB, addr 0x1003, rdata 0x80345678, ack in first ACCESS cycle → `rsp_data` 0xFFFFFF80, `rsp_err` 0, `rsp_valid` at cycle 2.
- LHU, addr 0x2002, rdata 0xBEEF1234 → `mem_addr` 0x2000, `mem_be` 1111, `rsp_data` 0x0000BEEF.
- SB, addr 0x3001, wdata 0x000000A5 → `mem_we` 1, `mem_be` 0010, `mem_wdata` 0xA5A5A5A5, `rsp_data` 0.
- LW, addr 0x4002 → `rsp_err` 1 at cycle 1, `mem_req` never asserted. Also SH at 0x4001 → same.
- TIMEOUT=4, load with no ack → `mem_req` high 4 cycles, then `rsp_err` pulse. Repeat with ack on the 4th cycle → normal response, no error.
- `rst_n` pulsed low during ACCESS → `mem_req` 0 immediately, `req_ready` 1 after release, and a subsequent LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and lane/alignment helpers for the
// load/store controller.
package lsu_pkg;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    localparam logic [2:0] SD_B  = 3'b000;
    localparam logic [2:0] SD_H  = 3'b001;
    localparam logic [2:0] SD_W  = 3'b010;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // Undefined load encodings behave as LW, so they take the word check.
    function automatic logic req_error(input logic we, input logic [2:0] ctrl,
                                       input logic [1:0] off);
        logic err_s;
        err_s = 1'b0;
        if (we) begin
            case (ctrl)
                SD_B:    err_s = 1'b0;
                SD_H:    err_s = off[0];
                SD_W:    err_s = |off;
                default: err_s = 1'b1;
            endcase
        end else begin
            case (ctrl)
                LD_B, LD_BU: err_s = 1'b0;
                LD_H, LD_HU: err_s = off[0];
                default:     err_s = |off;
            endcase
        end
        return err_s;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] ctrl, input logic [1:0] off);
        logic [3:0] be_s;
        case (ctrl)
            SD_B:    be_s = 4'b0001 << off;
            SD_H:    be_s = 4'b0011 << off;
            default: be_s = 4'b1111;
        endcase
        return be_s;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] ctrl, input logic [31:0] wdata);
        logic [31:0] wd_s;
        case (ctrl)
            SD_B:    wd_s = {4{wdata[7:0]}};
            SD_H:    wd_s = {2{wdata[15:0]}};
            default: wd_s = wdata;
        endcase
        return wd_s;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request, memory and response signals of the load/store controller.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_ctrl;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_rdata, mem_ack,
        output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
               rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_rdata, mem_ack,
        input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
               rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/load_extend.sv
// Aligns the addressed byte/halfword of a read word to bit 0 and extends it.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  ctrl_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted_s;

    // Shift the selected lane down, then extend according to the load type.
    always_comb begin
        shifted_s = rdata_i >> {offset_i, 3'b000};
        case (ctrl_i)
            LD_B:    result_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            LD_H:    result_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            LD_BU:   result_o = {24'h000000, shifted_s[7:0]};
            LD_HU:   result_o = {16'h0000, shifted_s[15:0]};
            default: result_o = shifted_s;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: alignment check, single memory access with timeout,
// and a one-cycle response pulse carrying the extended load data.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_ctrl_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [1:0]       off_q, off_d;
    logic             ready_q, ready_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      load_result_s;

    load_extend u_load_extend (
        .rdata_i  (bus.mem_rdata),
        .offset_i (off_q),
        .ctrl_i   (ctrl_q),
        .result_o (load_result_s)
    );

    // Next-state and registered-output computation for the IDLE/ACCESS/RESP sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ctrl_d      = ctrl_q;
        off_d       = off_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = 32'h0000_0000;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_error(bus.req_we, bus.req_ctrl, bus.req_addr[1:0])) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        cnt_d       = {CNT_W{1'b0}};
                        ctrl_d      = bus.req_ctrl;
                        off_d       = bus.req_addr[1:0];
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.req_we;
                        mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                        mem_be_d    = bus.req_we ? store_be(bus.req_ctrl, bus.req_addr[1:0]) : 4'b1111;
                        mem_wdata_d = bus.req_we ? store_wdata(bus.req_ctrl, bus.req_wdata) : 32'h0000_0000;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (bus.mem_ack || (cnt_q == CNT_LAST)) begin
                    // An ack in the final counted cycle still completes normally.
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ~bus.mem_ack;
                    rsp_data_d  = (bus.mem_ack && !mem_we_q) ? load_result_s : 32'h0000_0000;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'h0000_0000;
                    mem_be_d    = 4'b0000;
                    mem_wdata_d = 32'h0000_0000;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // State and output registers; reset drops any outstanding memory request at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            ctrl_q      <= 3'b000;
            off_q       <= 2'b00;
            ready_q     <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ctrl_q      <= ctrl_d;
            off_q       <= off_d;
            ready_q     <= ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, reset/idle-ack sequences and
// randomized transactions against a size/offset-based reference model.
module tb_lsu_ctrl;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    lsu_ctrl_if bus ();

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack;
        logic        err;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int acc_size(input logic we, input logic [2:0] c);
        if (we) return (c == 3'd0) ? 1 : (c == 3'd1) ? 2 : 4;
        return (c == 3'd0 || c == 3'd3) ? 1 : (c == 3'd1 || c == 3'd4) ? 2 : 4;
    endfunction

    function automatic logic m_err(input logic we, input logic [2:0] c, input logic [31:0] a);
        int low;
        if (we && c > 3'd2) return 1'b1;
        low = int'(a[1:0]);
        return (low % acc_size(we, c)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] c, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * int'(a[1:0]));
        case (c)
            3'd0: begin v = v & 32'd255;   if (v >= 32'd128)   v = v - 32'd256;   end
            3'd1: begin v = v & 32'd65535; if (v >= 32'd32768) v = v - 32'd65536; end
            3'd3: v = v & 32'd255;
            3'd4: v = v & 32'd65535;
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic we, input logic [2:0] c, input logic [31:0] a);
        int sz;
        sz = acc_size(we, c);
        if (!we || sz == 4) return 4'hF;
        return (sz == 2) ? (4'b0011 << a[1:0]) : (4'b0001 << a[1:0]);
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] c, input logic [31:0] w);
        int sz;
        sz = acc_size(1'b1, c);
        if (sz == 1) return {24'h0, w[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'h0, w[15:0]} * 32'h0001_0001;
        return w;
    endfunction

    // Starts and ends at a negedge with the DUT idle; ack index <0 or >=TO means no ack.
    task automatic do_txn(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int ack,
                          input logic e_err, input logic [31:0] e_data, input logic [3:0] e_be,
                          input logic [31:0] e_wd);
        int   i;
        logic done;
        logic e_to;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_ctrl  = ctrl;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = $urandom_range(0, 1) == 1;
        bus.req_ctrl  = 3'($urandom_range(0, 7));
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        e_to = 1'b0;
        if (e_err) begin
            chk("err_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("err_rsp_err", 32'(bus.rsp_err), 32'd1);
            chk("err_rsp_data", bus.rsp_data, 32'd0);
            chk("err_no_mem_req", 32'(bus.mem_req), 32'd0);
        end else begin
            i = 0;
            done = 1'b0;
            while (!done) begin
                chk("mem_req", 32'(bus.mem_req), 32'd1);
                chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
                chk("mem_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
                chk("mem_be", 32'(bus.mem_be), 32'(e_be));
                chk("mem_we", 32'(bus.mem_we), 32'(we));
                if (we) chk("mem_wdata", bus.mem_wdata, e_wd);
                bus.mem_ack   = (i == ack);
                bus.mem_rdata = (i == ack) ? rdata : $urandom;
                e_to = (i != ack) && (i == TO - 1);
                done = (i == ack) || (i == TO - 1);
                @(negedge clk);
                i++;
            end
            bus.mem_ack = 1'b0;
            chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("rsp_err", 32'(bus.rsp_err), 32'(e_to));
            chk("rsp_data", bus.rsp_data, e_to ? 32'd0 : e_data);
            chk("mem_req_drop", 32'(bus.mem_req), 32'd0);
        end
        @(negedge clk);
        chk("rsp_pulse_end", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        logic        r_we;
        logic [2:0]  r_ctrl;
        logic [31:0] r_addr, r_wd, r_rd;
        int          r_ack;

        //         we    ctrl  addr          wdata         rdata         ack  err   data          be       wd
        vecs[0]  = '{1'b0, 3'd0, 32'h0000_1003, 32'h0,        32'h8034_5678, 0,  1'b0, 32'hFFFF_FF80, 4'hF,    32'h0};
        vecs[1]  = '{1'b0, 3'd4, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0,  1'b0, 32'h0000_BEEF, 4'hF,    32'h0};
        vecs[2]  = '{1'b1, 3'd0, 32'h0000_3001, 32'h0000_00A5, 32'h0,        0,  1'b0, 32'h0,         4'b0010, 32'hA5A5_A5A5};
        vecs[3]  = '{1'b0, 3'd2, 32'h0000_4002, 32'h0,        32'h0,        0,  1'b1, 32'h0,         4'hF,    32'h0};
        vecs[4]  = '{1'b1, 3'd1, 32'h0000_4001, 32'h1234_5678, 32'h0,        0,  1'b1, 32'h0,         4'hF,    32'h0};
        vecs[5]  = '{1'b1, 3'd3, 32'h0000_5000, 32'h1234_5678, 32'h0,        0,  1'b1, 32'h0,         4'hF,    32'h0};
        vecs[6]  = '{1'b0, 3'd5, 32'h0000_6000, 32'h0,        32'h1234_5678, 1,  1'b0, 32'h1234_5678, 4'hF,    32'h0};
        vecs[7]  = '{1'b0, 3'd6, 32'h0000_6001, 32'h0,        32'h0,        0,  1'b1, 32'h0,         4'hF,    32'h0};
        vecs[8]  = '{1'b0, 3'd1, 32'h0000_7002, 32'h0,        32'h8001_0000, 0,  1'b0, 32'hFFFF_8001, 4'hF,    32'h0};
        vecs[9]  = '{1'b0, 3'd2, 32'h0000_8000, 32'h0,        32'h0,        -1, 1'b0, 32'h0,         4'hF,    32'h0};
        vecs[10] = '{1'b0, 3'd2, 32'h0000_8004, 32'h0,        32'hCAFE_F00D, 3,  1'b0, 32'hCAFE_F00D, 4'hF,    32'h0};
        vecs[11] = '{1'b1, 3'd1, 32'h0000_9002, 32'h1234_BEEF, 32'h0,        0,  1'b0, 32'h0,         4'b1100, 32'hBEEF_BEEF};
        vecs[12] = '{1'b1, 3'd2, 32'h0000_A000, 32'hDEAD_BEEF, 32'h0,        2,  1'b0, 32'h0,         4'hF,    32'hDEAD_BEEF};
        vecs[13] = '{1'b0, 3'd3, 32'h0000_B002, 32'h0,        32'h00FE_0000, 0,  1'b0, 32'h0000_00FE, 4'hF,    32'h0};

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_ctrl  = 3'd0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.mem_rdata = 32'h0;
        bus.mem_ack   = 1'b0;

        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 14; k++) begin
            do_txn(vecs[k].we, vecs[k].ctrl, vecs[k].addr, vecs[k].wdata, vecs[k].rdata,
                   vecs[k].ack, vecs[k].err, vecs[k].data, vecs[k].be, vecs[k].wd);
        end

        // Acks while idle must not produce a response or a request.
        bus.mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_ack_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("idle_ack_req", 32'(bus.mem_req), 32'd0);
        end
        bus.mem_ack = 1'b0;

        // Reset in the middle of an access abandons it asynchronously.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_ctrl  = 3'd2;
        bus.req_addr  = 32'h0000_C000;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", 32'(bus.mem_req), 32'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("post_rst_rsp", 32'(bus.rsp_valid), 32'd0);
        do_txn(1'b0, 3'd2, 32'h0000_C004, 32'h0, 32'h1357_9BDF, 0, 1'b0, 32'h1357_9BDF, 4'hF, 32'h0);

        for (int k = 0; k < 300; k++) begin
            r_we   = $urandom_range(0, 1) == 1;
            r_ctrl = 3'($urandom_range(0, r_we ? 3 : 7));
            r_addr = $urandom;
            r_wd   = $urandom;
            r_rd   = $urandom;
            r_ack  = $urandom_range(0, 5);
            do_txn(r_we, r_ctrl, r_addr, r_wd, r_rd, r_ack, m_err(r_we, r_ctrl, r_addr),
                   r_we ? 32'd0 : m_load(r_ctrl, r_addr, r_rd),
                   m_be(r_we, r_ctrl, r_addr), m_wd(r_ctrl, r_wd));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
